// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone classic interconnect: round-robin arbitration between masters,
// decode-error termination for unmapped slave slots and a per-transfer watchdog.
module wb_rr_interconnect #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  output logic [NUM_MASTERS*DW-1:0]   m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  input  logic [NUM_SLAVES*DW-1:0]    s_dat_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_err_i,
  input  logic [NUM_SLAVES-1:0]       s_rty_i,
  output logic [NUM_MASTERS-1:0]      gnt_o,
  output logic                        tmo_o
);

  localparam int MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW  = DW / 8;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int WCW = (TW < 8) ? 8 : TW;
  localparam logic [WCW-1:0] WLIM = (TIMEOUT == 0) ? '0 : WCW'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [MW-1:0]          gidx_q, gidx_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic                   derr_q, derr_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;

  logic          busy;
  logic          hi_found, lo_found, req_found;
  logic [MW-1:0] hi_idx, lo_idx, req_idx;

  logic          g_cyc, g_stb, g_we;
  logic [SW-1:0] g_sel;
  logic [AW-1:0] g_adr;
  logic [DW-1:0] g_dat;

  logic [3:0]    sidx;
  logic          mapped;
  logic          sel_ack, sel_err, sel_rty;
  logic [DW-1:0] sel_dat;
  logic          any_resp, fire;

  assign busy = (state_q == ST_BUSY);

  // Round-robin search: lowest requester at or above ptr, else lowest below it (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
      if (m_cyc_i[m]) begin
        if (m >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = MW'(m);
        end else begin
          lo_found = 1'b1;
          lo_idx   = MW'(m);
        end
      end
    end
    req_found = hi_found | lo_found;
    req_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_sel = '0;
    g_adr = '0;
    g_dat = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (busy && gidx_q == MW'(m)) begin
        g_cyc = m_cyc_i[m];
        g_stb = m_stb_i[m];
        g_we  = m_we_i[m];
        g_sel = m_sel_i[m*SW +: SW];
        g_adr = m_adr_i[m*AW +: AW];
        g_dat = m_dat_i[m*DW +: DW];
      end
    end
  end

  assign sidx   = g_adr[AW-1:AW-4];
  assign mapped = (int'(sidx) < NUM_SLAVES);

  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_rty = 1'b0;
    sel_dat = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (busy && int'(sidx) == s) begin
        sel_ack = s_ack_i[s];
        sel_err = s_err_i[s];
        sel_rty = s_rty_i[s];
        sel_dat = s_dat_i[s*DW +: DW];
      end
    end
  end

  // A real termination in the limit cycle beats the watchdog, so fire excludes any response.
  assign any_resp = sel_ack | sel_err | sel_rty | derr_q;
  assign fire     = (TIMEOUT != 0) && g_stb && !any_resp && (wcnt_q == WLIM);

  always_comb begin
    derr_d = g_stb && !mapped && !derr_q;
    wcnt_d = (!g_stb || any_resp || fire) ? '0 : wcnt_q + 1'b1;
  end

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (busy && int'(sidx) == s) begin
        s_cyc_o[s] = g_cyc;
        s_stb_o[s] = g_stb & ~fire;
      end
    end
  end

  assign s_we_o  = g_we;
  assign s_sel_o = g_sel;
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;

  always_comb begin
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    m_dat_o = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (busy && gidx_q == MW'(m)) begin
        m_ack_o[m]           = sel_ack;
        m_err_o[m]           = sel_err | derr_q | fire;
        m_rty_o[m]           = sel_rty;
        m_dat_o[m*DW +: DW]  = sel_dat;
      end
    end
  end

  // Grant is held until the owner drops cyc; the release cycle forces one idle bus cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          state_d = ST_BUSY;
          gidx_d  = req_idx;
          gnt_d   = '0;
          for (int m = 0; m < NUM_MASTERS; m++) begin
            if (req_idx == MW'(m)) gnt_d[m] = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == MW'(NUM_MASTERS - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      derr_q  <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      derr_q  <= derr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign gnt_o = gnt_q;
  assign tmo_o = fire;

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Self-checking bench for wb_rr_interconnect: responses are matched against a queue of
// expected terminations, plus cycle-exact checks of grant, strobes and watchdog timing.
module tb_wb_rr_interconnect;

  localparam int NM  = 2;
  localparam int NS  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*DW-1:0] m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic             s_we_o;
  logic [SW-1:0]    s_sel_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]    gnt_o;
  logic             tmo_o;

  logic [NS-1:0]    ack_mask;

  typedef struct {
    int          master;
    bit          is_err;
    bit          is_tmo;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [NM-1:0] acked;
  logic [NM-1:0] prev_gnt;
  int            gap;
  int            grants_seen;

  always #5 clk = ~clk;

  wb_rr_interconnect #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .AW(AW), .DW(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .tmo_o(tmo_o)
  );

  function automatic logic [31:0] slave_data(input int s);
    return 32'hC0DE_0000 + 32'(s) * 32'h111;
  endfunction

  // Slaves ack on cyc (not stb) so the bench never closes a loop through the watchdog gate.
  assign s_ack_i = s_cyc_o & ack_mask;
  assign s_err_i = '0;
  assign s_rty_i = '0;

  always_comb begin
    s_dat_i = '0;
    for (int s = 0; s < NS; s++) s_dat_i[s*DW +: DW] = slave_data(s);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_sel_i[m*SW +: SW] = '1;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = dat;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clk);
  endtask

  task automatic pushExp(input int m, input bit is_err, input bit is_tmo, input logic [31:0] data);
    exp_t e;
    e.master = m;
    e.is_err = is_err;
    e.is_tmo = is_tmo;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  task automatic dropAll();
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    dropAll();
    ack_mask = '1;
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  // Every termination seen on a master port must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < NM; m++) begin
        if (m_ack_o[m] | m_err_o[m] | m_rty_o[m]) begin
          if (sb_q.size() == 0) begin
            checkOutput("sb_unexpected_resp", 64'(m), 64'hFF);
          end else begin
            mon_e = sb_q.pop_front();
            checkOutput("sb_master", 64'(m), 64'(mon_e.master));
            checkOutput("sb_err", m_err_o[m], mon_e.is_err);
            checkOutput("sb_ack", m_ack_o[m], !mon_e.is_err);
            checkOutput("sb_tmo", tmo_o, mon_e.is_tmo);
            if (!mon_e.is_err) checkOutput("sb_data", m_dat_o[m*DW +: DW], mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
    ack_mask = '1;

    // Reset state
    sampleNow();
    checkOutput("rst_gnt", gnt_o, 0);
    checkOutput("rst_stb", s_stb_o, 0);
    checkOutput("rst_cyc", s_cyc_o, 0);
    checkOutput("rst_ack", m_ack_o, 0);
    checkOutput("rst_tmo", tmo_o, 0);

    // Single read by master 0 from slave 1, immediate ack
    doReset();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
    pushExp(0, 1'b0, 1'b0, slave_data(1));
    sampleNow();
    checkOutput("t1_c0_gnt", gnt_o, 0);
    nextCycle(); sampleNow();
    checkOutput("t1_c1_gnt", gnt_o, 2'b01);
    checkOutput("t1_c1_stb", s_stb_o, 4'b0010);
    checkOutput("t1_c1_cyc", s_cyc_o, 4'b0010);
    checkOutput("t1_c1_adr", s_adr_o, 32'h1000_0004);
    checkOutput("t1_c1_other_dat", m_dat_o[2*DW-1:DW], 0);
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); sampleNow();
    checkOutput("t1_c2_gnt", gnt_o, 2'b01);
    nextCycle(); sampleNow();
    checkOutput("t1_c3_gnt", gnt_o, 0);

    // Two masters competing, each dropping cyc for one cycle after its ack
    doReset();
    for (int k = 0; k < 2; k++) begin
      pushExp(0, 1'b0, 1'b0, slave_data(0));
      pushExp(1, 1'b0, 1'b0, slave_data(3));
    end
    acked = '0; prev_gnt = '0; gap = 0; grants_seen = 0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) nextCycle();
      applyStimulus(0, !acked[0], !acked[0], 1'b0, 32'h0000_0010, 32'h0);
      applyStimulus(1, !acked[1], !acked[1], 1'b0, 32'h3000_0020, 32'h0);
      sampleNow();
      acked = m_ack_o;
      if (gnt_o == '0) begin
        gap++;
      end else if (gnt_o != prev_gnt) begin
        if (grants_seen > 0) checkOutput("t2_gap", 64'(gap), 1);
        checkOutput("t2_gnt", gnt_o, (grants_seen % 2 == 0) ? 2'b01 : 2'b10);
        grants_seen++;
        gap = 0;
      end
      prev_gnt = gnt_o;
    end
    checkOutput("t2_grants", 64'(grants_seen), 4);
    nextCycle(); dropAll(); sampleNow();
    nextCycle(); sampleNow();

    // Unmapped slot from master 1: err exactly one cycle after the strobe
    doReset();
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h5000_0000, 32'hDEAD_BEEF);
    pushExp(1, 1'b1, 1'b0, 32'h0);
    sampleNow();
    nextCycle(); sampleNow();
    checkOutput("t3_c1_gnt", gnt_o, 2'b10);
    checkOutput("t3_c1_stb", s_stb_o, 0);
    checkOutput("t3_c1_cyc", s_cyc_o, 0);
    checkOutput("t3_c1_err", m_err_o, 0);
    nextCycle(); sampleNow();
    checkOutput("t3_c2_err", m_err_o, 2'b10);
    nextCycle(); dropAll(); sampleNow();
    checkOutput("t3_c3_err", m_err_o, 0);
    nextCycle(); sampleNow();

    // Hung slave 2: watchdog fires TIMEOUT-1 cycles after the strobe starts
    doReset();
    ack_mask = 4'b1011;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    pushExp(0, 1'b1, 1'b1, 32'h0);
    sampleNow();
    for (int c = 1; c <= TMO; c++) begin
      nextCycle(); sampleNow();
      checkOutput($sformatf("t4_c%0d_stb2", c), s_stb_o[2], (c < TMO));
      checkOutput($sformatf("t4_c%0d_tmo", c), tmo_o, (c == TMO));
      checkOutput($sformatf("t4_c%0d_err0", c), m_err_o[0], (c == TMO));
    end
    nextCycle(); dropAll(); sampleNow();
    checkOutput("t4_after_tmo", tmo_o, 0);
    nextCycle(); sampleNow();

    // Slave ack lands in the cycle the watchdog would fire: ack wins
    doReset();
    ack_mask = 4'b1011;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h2000_0008, 32'h0);
    pushExp(0, 1'b0, 1'b0, slave_data(2));
    sampleNow();
    for (int c = 1; c < TMO; c++) begin
      nextCycle(); sampleNow();
    end
    nextCycle(); ack_mask = 4'b1111; sampleNow();
    checkOutput("t5_ack", m_ack_o, 2'b01);
    checkOutput("t5_err", m_err_o, 0);
    checkOutput("t5_tmo", tmo_o, 0);
    checkOutput("t5_stb", s_stb_o, 4'b0100);
    nextCycle(); dropAll(); sampleNow();
    nextCycle(); sampleNow();

    // Reset mid-transfer while master 1 holds the bus and ptr points at master 1
    doReset();
    ack_mask = 4'b1011;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    pushExp(0, 1'b0, 1'b0, slave_data(1));
    sampleNow();
    nextCycle(); sampleNow();
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 32'h0); sampleNow();
    nextCycle();
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    sampleNow();
    checkOutput("t6_c3_gnt", gnt_o, 0);
    nextCycle(); sampleNow();
    checkOutput("t6_c4_gnt", gnt_o, 2'b10);
    checkOutput("t6_c4_stb", s_stb_o, 4'b0100);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_gnt", gnt_o, 0);
    checkOutput("t6_rst_stb", s_stb_o, 0);
    checkOutput("t6_rst_cyc", s_cyc_o, 0);
    checkOutput("t6_rst_ack", m_ack_o, 0);
    checkOutput("t6_rst_err", m_err_o, 0);
    nextCycle();
    nextCycle();
    pushExp(0, 1'b0, 1'b0, slave_data(1));
    rst_n = 1'b1;
    sampleNow();
    checkOutput("t6_rel_gnt_idle", gnt_o, 0);
    nextCycle(); sampleNow();
    checkOutput("t6_first_gnt", gnt_o, 2'b01);
    nextCycle(); dropAll(); sampleNow();
    nextCycle(); sampleNow();

    checkOutput("sb_drained", 64'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
